main_memory_responder: RTL and testbench



---
 rtl/main_memory_responder_if.sv | 32 +++
 rtl/main_memory_responder.sv | 140 ++++++++++++++
 tb/tb_main_memory_responder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/main_memory_responder_if.sv
// +----------------------------------------------------------------------------+
// | main_memory_responder_if                                                   |
// | Bus-to-memory request/response bundle with bus (master) and memory (slave) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface main_memory_responder_if #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 32
);
  logic                     mem_req_valid;
  logic                     mem_req_write;
  logic [ADDRESS_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0]    mem_req_data;
  logic                     mem_resp_valid;
  logic [DATA_WIDTH-1:0]    mem_resp_data;
  logic                     busy;
  logic                     overflow;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    input  mem_resp_valid, mem_resp_data, busy, overflow
  );

  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    output mem_resp_valid, mem_resp_data, busy, overflow
  );
endinterface

`default_nettype wire

// File: rtl/main_memory_responder.sv
// +----------------------------------------------------------------------------+
// | main_memory_responder                                                      |
// | In-order memory responder: request FIFO, word storage, fixed-latency reads |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module main_memory_responder #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int READ_LATENCY  = 3
) (
  input  wire logic              clk,
  input  wire logic              reset,
  main_memory_responder_if.slave bus
);

  localparam int c_mem_words = 2 ** ADDRESS_WIDTH;
  localparam int c_ptr_w     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w     = $clog2(FIFO_DEPTH + 1);
  localparam int c_lat_w     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_lat_w-1:0] c_lat_load = c_lat_w'(READ_LATENCY - 1);

  localparam logic [0:0] c_st_idle      = 1'b0;
  localparam logic [0:0] c_st_read_wait = 1'b1;

  logic [DATA_WIDTH-1:0]    r_mem [c_mem_words];

  logic                     r_fifo_write [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_fifo_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    r_fifo_data  [FIFO_DEPTH];
  logic [c_ptr_w-1:0]       r_wr_ptr;
  logic [c_ptr_w-1:0]       r_rd_ptr;
  logic [c_cnt_w-1:0]       r_count;

  logic [0:0]               r_state;
  logic [c_lat_w-1:0]       r_lat_cnt;
  logic [ADDRESS_WIDTH-1:0] r_lat_addr;
  logic                     r_resp_valid;
  logic [DATA_WIDTH-1:0]    r_resp_data;
  logic                     r_busy;
  logic                     r_overflow;

  logic                     w_pop;
  logic                     w_push_ok;
  logic                     w_drop;
  logic                     w_head_write;
  logic [ADDRESS_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0]    w_head_data;
  logic [c_cnt_w-1:0]       w_count_nxt;
  logic [0:0]               w_state_nxt;

  assign w_head_write = r_fifo_write[r_rd_ptr];
  assign w_head_addr  = r_fifo_addr[r_rd_ptr];
  assign w_head_data  = r_fifo_data[r_rd_ptr];

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push then.
  assign w_pop       = (r_state == c_st_idle) && (r_count != '0);
  assign w_push_ok   = bus.mem_req_valid && ((r_count < c_depth) || w_pop);
  assign w_drop      = bus.mem_req_valid && !w_push_ok;
  assign w_count_nxt = r_count + c_cnt_w'(w_push_ok) - c_cnt_w'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:      if (w_pop && !w_head_write) w_state_nxt = c_st_read_wait;
      c_st_read_wait: if (r_lat_cnt == '0)        w_state_nxt = c_st_idle;
      default:        w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo_write[r_wr_ptr] <= bus.mem_req_write;
      r_fifo_addr[r_wr_ptr]  <= bus.mem_req_addr;
      r_fifo_data[r_wr_ptr]  <= bus.mem_req_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_mem_words; i++) r_mem[i] <= '0;
    end else if (w_pop && w_head_write) begin
      r_mem[w_head_addr] <= w_head_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_state      <= c_st_idle;
      r_lat_cnt    <= '0;
      r_lat_addr   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_busy       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_count      <= w_count_nxt;
      r_state      <= w_state_nxt;
      r_busy       <= (w_count_nxt != '0) || (w_state_nxt != c_st_idle);
      if (w_push_ok) r_wr_ptr   <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr   <= r_rd_ptr + 1'b1;
      if (w_drop)    r_overflow <= 1'b1;

      case (r_state)
        c_st_idle: begin
          if (w_pop && !w_head_write) begin
            r_lat_addr <= w_head_addr;
            r_lat_cnt  <= c_lat_load;
          end
        end
        c_st_read_wait: begin
          // Storage is sampled at response time so earlier-queued writes are visible.
          if (r_lat_cnt != '0) begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end else begin
            r_resp_data  <= r_mem[r_lat_addr];
            r_resp_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_resp_valid = r_resp_valid;
  assign bus.mem_resp_data  = r_resp_data;
  assign bus.busy           = r_busy;
  assign bus.overflow       = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_main_memory_responder.sv
// +----------------------------------------------------------------------------+
// | tb_main_memory_responder                                                   |
// | Directed self-checking bench for main_memory_responder                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_main_memory_responder;

  logic clk;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   e0;
  int   last_edge;

  logic [31:0] rq_data [$];
  int          rq_edge [$];

  main_memory_responder_if #(.ADDRESS_WIDTH(6), .DATA_WIDTH(32)) bus_if ();

  main_memory_responder #(
    .ADDRESS_WIDTH(6),
    .DATA_WIDTH   (32),
    .FIFO_DEPTH   (4),
    .READ_LATENCY (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Each entry records the response data and the edge that registered it.
  always @(negedge clk) begin
    if (bus_if.mem_resp_valid === 1'b1) begin
      rq_data.push_back(bus_if.mem_resp_data);
      rq_edge.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic w, input logic [5:0] a, input logic [31:0] d);
    bus_if.mem_req_valid = 1'b1;
    bus_if.mem_req_write = w;
    bus_if.mem_req_addr  = a;
    bus_if.mem_req_data  = d;
    @(posedge clk);
    #1;
    last_edge = cyc;
    bus_if.mem_req_valid = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    rq_data.delete();
    rq_edge.delete();
  endtask

  function automatic logic [31:0] q_data(input int i);
    return (rq_data.size() > i) ? rq_data[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] q_edge(input int i);
    return (rq_edge.size() > i) ? 32'(rq_edge[i]) : 32'hxxxxxxxx;
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus_if.mem_req_valid = 1'b0;
    bus_if.mem_req_write = 1'b0;
    bus_if.mem_req_addr  = '0;
    bus_if.mem_req_data  = '0;
    reset = 1'b1;
    #2;
    chk("rst_resp_valid", 32'(bus_if.mem_resp_valid), 32'd0);
    chk("rst_resp_data",  bus_if.mem_resp_data,       32'd0);
    chk("rst_busy",       32'(bus_if.busy),           32'd0);
    chk("rst_overflow",   32'(bus_if.overflow),       32'd0);
    wait_neg(2);
    reset = 1'b0;
    wait_neg(1);

    // Write then read of the same word: write pops E1, read pops E2, response E5.
    clear_q();
    send(1'b1, 6'd5, 32'hDEADBEEF);
    e0 = last_edge;
    send(1'b0, 6'd5, 32'h0);
    wait_neg(12);
    chk("wr_rd_count", 32'(rq_data.size()), 32'd1);
    chk("wr_rd_data",  q_data(0),           32'hDEADBEEF);
    chk("wr_rd_edge",  q_edge(0),           32'(e0 + 5));
    chk("wr_rd_busy",  32'(bus_if.busy),    32'd0);

    // Back-to-back reads: pops at E3 and E7, responses at E6 and E10.
    clear_q();
    send(1'b1, 6'd1, 32'h11);
    e0 = last_edge;
    send(1'b1, 6'd2, 32'h22);
    send(1'b0, 6'd1, 32'h0);
    send(1'b0, 6'd2, 32'h0);
    wait_neg(16);
    chk("b2b_count",  32'(rq_data.size()), 32'd2);
    chk("b2b_data0",  q_data(0),           32'h11);
    chk("b2b_data1",  q_data(1),           32'h22);
    chk("b2b_edge0",  q_edge(0),           32'(e0 + 6));
    chk("b2b_gap",    q_edge(1) - q_edge(0), 32'd4);

    // Preload addrs 10..16 with 0xA0..0xA6 for the overflow sequence.
    for (int i = 0; i < 7; i++) send(1'b1, 6'(10 + i), 32'hA0 + 32'(i));
    wait_neg(10);
    clear_q();
    // Read 10 at E0 pops E1; reads 11..14 fill the FIFO by E4; read 15 at E5
    // lands on a full FIFO while 11 pops; read 16 at E6 finds it full in READ_WAIT.
    send(1'b0, 6'd10, 32'h0);
    e0 = last_edge;
    for (int i = 11; i < 15; i++) send(1'b0, 6'(i), 32'h0);
    send(1'b0, 6'd15, 32'h0);
    chk("full_push_pop_ovf", 32'(bus_if.overflow), 32'd0);
    send(1'b0, 6'd16, 32'h0);
    chk("ovf_set", 32'(bus_if.overflow), 32'd1);
    wait_neg(30);
    chk("ovf_sticky", 32'(bus_if.overflow), 32'd1);
    chk("ovf_count",  32'(rq_data.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ovf_data%0d", i), q_data(i), 32'hA0 + 32'(i));
      chk($sformatf("ovf_edge%0d", i), q_edge(i), 32'(e0 + 4 + 4 * i));
    end

    // Asynchronous reset mid-cycle with overflow set and resp_data non-zero.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_resp_valid", 32'(bus_if.mem_resp_valid), 32'd0);
    chk("mid_rst_resp_data",  bus_if.mem_resp_data,       32'd0);
    chk("mid_rst_busy",       32'(bus_if.busy),           32'd0);
    chk("mid_rst_overflow",   32'(bus_if.overflow),       32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_neg(1);
    clear_q();
    send(1'b0, 6'd63, 32'h0);
    send(1'b0, 6'd10, 32'h0);
    wait_neg(12);
    chk("post_rst_count", 32'(rq_data.size()), 32'd2);
    chk("post_rst_a63",   q_data(0),           32'h0);
    chk("post_rst_a10",   q_data(1),           32'h0);

    // Reset one cycle after a read pops: the in-flight response must vanish.
    send(1'b1, 6'd7, 32'h1234);
    wait_neg(5);
    clear_q();
    send(1'b0, 6'd7, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rd_rst_busy", 32'(bus_if.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_neg(10);
    chk("rd_rst_no_resp", 32'(rq_data.size()), 32'd0);
    chk("rd_rst_busy2",   32'(bus_if.busy),    32'd0);
    send(1'b0, 6'd7, 32'h0);
    wait_neg(8);
    chk("rd_rst_count", 32'(rq_data.size()), 32'd1);
    chk("rd_rst_a7",    q_data(0),           32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
